// File: rtl/param_reload_down_counter.sv
// param_reload_down_counter
//   Reloadable down counter with a one-shot mode and a periodic (auto-reload) mode.
//   A load strobe captures a reload value. The counter then steps down to a terminal
//   count, where it raises a single-cycle tc pulse. In periodic mode it reloads and
//   keeps running; in one-shot mode it stops and goes idle.
//
//   Optional feature: define RDC_PRESCALE_EN to add a prescaler. With it, only every
//   PRESCALE-th enabled RUN cycle counts as a step.
//
// Parameters
//   WIDTH    : counter and reload width (2..32)
//   PRESCALE : enabled RUN cycles per step (2..256); used only with RDC_PRESCALE_EN
// Ports
//   baud    : clock; all state updates on its rising edge
//   rst     : synchronous active-high reset
//   load    : reload strobe; has priority over en and auto_rl
//   sel     : reload value, sampled when load=1
//   en      : count enable
//   auto_rl : 1 = periodic mode, 0 = one-shot mode; sampled on the terminal step
//   cnt     : current count (registered)
//   busy    : high while the FSM is in RUN
//   tc      : registered single-cycle terminal-count pulse
module param_reload_down_counter #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned PRESCALE = 16
) (
  input  logic             baud,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] sel,
  input  logic             en,
  input  logic             auto_rl,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc
);

  // Reject illegal parameter values at elaboration time
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_reload_down_counter: WIDTH must be in 2..32");
  end
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("param_reload_down_counter: PRESCALE must be in 2..256");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rl, rl_d, cnt_d;
  logic             tc_d;
  logic             step;

`ifdef RDC_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
`endif

  // State and datapath registers
  always_ff @(posedge baud) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      rl      <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      rl      <= rl_d;
      tc      <= tc_d;
    end
  end

`ifdef RDC_PRESCALE_EN
  // Prescale counter register
  always_ff @(posedge baud) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`endif

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt;
    rl_d    = rl;
    tc_d    = 1'b0;
    step    = 1'b0;
`ifdef RDC_PRESCALE_EN
    pre_d   = pre_q;
`endif
    if (load) begin
      rl_d    = sel;
      cnt_d   = sel;
      state_d = (sel != '0) ? RUN : IDLE;
`ifdef RDC_PRESCALE_EN
      pre_d   = '0;
`endif
    end else if (state_q == RUN && en) begin
`ifdef RDC_PRESCALE_EN
      if (pre_q == PW'(PRESCALE - 1)) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
`else
      step = 1'b1;
`endif
      if (step) begin
        if (cnt > WIDTH'(1)) begin
          cnt_d = cnt - WIDTH'(1);
        end else if (cnt == WIDTH'(1)) begin
          // Terminal step: pulse tc, then reload or stop
          tc_d = 1'b1;
          if (auto_rl) begin
            cnt_d = rl;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          // A zero count in RUN cannot be reached; drop to IDLE rather than wrap
          state_d = IDLE;
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_param_reload_down_counter.sv
module tb_param_reload_down_counter;

  localparam int unsigned WIDTH = 10;
`ifdef RDC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic             baud = 1'b0;
  logic             rst, load, en, auto_rl;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] cnt;
  logic             busy, tc;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cnt, m_rl, m_pre;
  bit m_run, m_tc;

  param_reload_down_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .baud(baud), .rst(rst), .load(load), .sel(sel), .en(en),
    .auto_rl(auto_rl), .cnt(cnt), .busy(busy), .tc(tc)
  );

  always #5 baud = ~baud;

  // Behavioural model: one clock of the counter, from the rules
  task automatic model_clock(input bit r, input bit l, input int s, input bit e, input bit a);
    if (r) begin
      m_cnt = 0; m_rl = 0; m_pre = 0; m_run = 0; m_tc = 0;
    end else if (l) begin
      m_rl = s; m_cnt = s; m_pre = 0; m_tc = 0; m_run = (s != 0);
    end else begin
      m_tc = 0;
      if (m_run && e) begin
        m_pre = m_pre + 1;
        if (m_pre == PS) begin
          m_pre = 0;
          if (m_cnt > 1) m_cnt = m_cnt - 1;
          else begin
            m_tc = 1;
            if (a) m_cnt = m_rl;
            else begin m_cnt = 0; m_run = 0; end
          end
        end
      end
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the model; outputs sampled #1 later
  task automatic cycle(input bit r, input bit l, input int s, input bit e, input bit a);
    @(negedge baud);
    rst = r; load = l; sel = WIDTH'(s); en = e; auto_rl = a;
    @(posedge baud);
    model_clock(r, l, s, e, a);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 5, 1, 1);
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL reset cnt=%0d busy=%b tc=%b required cnt=0 busy=0 tc=0", cnt, busy, tc);
    end
  endtask

  task automatic test_oneshot();
    cycle(0, 1, 5, 1, 0);
    checks++;
    if (cnt !== WIDTH'(5) || busy !== 1'b1 || tc !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_load cnt=%0d busy=%b tc=%b required 5/1/0", cnt, busy, tc);
    end
    for (int i = 0; i < 5 * PS; i++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (cnt !== WIDTH'(m_cnt) || busy !== m_run || tc !== m_tc) begin
        failures++;
        $display("FAIL oneshot_run i=%0d cnt=%0d busy=%b tc=%b required %0d/%b/%b",
                 i, cnt, busy, tc, m_cnt, m_run, m_tc);
      end
    end
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_end cnt=%0d busy=%b tc=%b required 0/0/1", cnt, busy, tc);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_hold i=%0d cnt=%0d busy=%b tc=%b required 0/0/0", i, cnt, busy, tc);
      end
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    cycle(0, 1, 3, 1, 1);
    for (int i = 0; i < 9 * PS; i++) begin
      cycle(0, 0, 0, 1, 1);
      if (tc === 1'b1) pulses++;
      checks++;
      if (cnt !== WIDTH'(m_cnt) || busy !== 1'b1 || tc !== m_tc) begin
        failures++;
        $display("FAIL periodic i=%0d cnt=%0d busy=%b tc=%b required %0d/1/%b",
                 i, cnt, busy, tc, m_cnt, m_tc);
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL periodic_pulses got=%0d required=3", pulses);
    end
    // rl==1 periodic: tc on every step, cnt stays 1
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 2 * PS; i++) begin
      cycle(0, 0, 0, 1, 1);
      checks++;
      if (cnt !== WIDTH'(1) || tc !== m_tc || busy !== 1'b1) begin
        failures++;
        $display("FAIL periodic_rl1 i=%0d cnt=%0d tc=%b busy=%b required 1/%b/1", i, cnt, tc, busy, m_tc);
      end
    end
  endtask

  task automatic test_pause_collision();
    cycle(0, 1, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (cnt !== WIDTH'(4) || tc !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL pause i=%0d cnt=%0d tc=%b busy=%b required 4/0/1", i, cnt, tc, busy);
      end
    end
    for (int i = 0; i < 4 * PS - 1; i++) cycle(0, 0, 0, 1, 0);
    checks++;
    if (cnt !== WIDTH'(1) || cnt !== WIDTH'(m_cnt)) begin
      failures++;
      $display("FAIL collision_setup cnt=%0d required 1", cnt);
    end
    // Next enabled cycle would be the terminal step; load wins
    cycle(0, 1, 7, 1, 0);
    checks++;
    if (cnt !== WIDTH'(7) || tc !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL collision cnt=%0d tc=%b busy=%b required 7/0/1", cnt, tc, busy);
    end
  endtask

  task automatic test_zero_reset();
    cycle(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b0) begin
        failures++;
        $display("FAIL zero_load i=%0d cnt=%0d busy=%b tc=%b required 0/0/0", i, cnt, busy, tc);
      end
      cycle(0, 0, 0, 1, 1);
    end
    cycle(0, 1, 6, 1, 0);
    checks++;
    if (cnt !== WIDTH'(6) || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup cnt=%0d busy=%b required 6/1", cnt, busy);
    end
    cycle(1, 1, 9, 1, 1);
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL rst_load cnt=%0d busy=%b tc=%b required 0/0/0", cnt, busy, tc);
    end
  endtask

  task automatic test_prescale();
    int n;
    cycle(0, 1, 2, 1, 0);
    for (int i = 0; i < PS; i++) cycle(0, 0, 0, 1, 0);
    checks++;
    if (cnt !== WIDTH'(1) || tc !== 1'b0) begin
      failures++;
      $display("FAIL prescale_first cnt=%0d tc=%b required 1/0", cnt, tc);
    end
    for (int i = 0; i < PS; i++) cycle(0, 0, 0, 1, 0);
    checks++;
    if (cnt !== '0 || tc !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL prescale_term cnt=%0d tc=%b busy=%b required 0/1/0", cnt, tc, busy);
    end
    // Two paused cycles after the first enabled cycle stretch the run by 2
    cycle(0, 1, 2, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n = 3;
    while (tc !== 1'b1 && n < 40) begin
      cycle(0, 0, 0, 1, 0);
      n++;
    end
    checks++;
    if (n != 2 * PS + 2) begin
      failures++;
      $display("FAIL prescale_pause cycles=%0d required=%0d", n, 2 * PS + 2);
    end
  endtask

  task automatic test_random();
    bit r, l, e, a;
    int s;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 3) != 0);
      a = $urandom_range(0, 1);
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 6));
      cycle(r, l, s, e, a);
      checks++;
      if (cnt !== WIDTH'(m_cnt) || busy !== m_run || tc !== m_tc) begin
        failures++;
        $display("FAIL random i=%0d cnt=%0d busy=%b tc=%b required %0d/%b/%b",
                 i, cnt, busy, tc, m_cnt, m_run, m_tc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; sel = '0; en = 1'b0; auto_rl = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_collision();
    test_zero_reset();
    test_prescale();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_reload_down_counter.md
PARAM_RELOAD_DOWN_COUNTER -- requirements
Module: param_reload_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10, which sets the counter and reload bit width (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE, default 16, which sets the number of enabled cycles per count step; it is used only when RDC_PRESCALE_EN is defined, legal range 2..256.
REQ-003 SHALL have port baud, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load, input, 1 bit: synchronous reload strobe.
REQ-006 SHALL have port sel, input, WIDTH bits: reload value, sampled when load=1.
REQ-007 SHALL have port en, input, 1 bit: count enable.
REQ-008 SHALL have port auto_rl, input, 1 bit: 1 selects periodic mode, 0 selects one-shot mode.
REQ-009 SHALL have port cnt, output, WIDTH bits: current count, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-011 SHALL have port tc, output, 1 bit: registered single-cycle terminal-count pulse.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, plus an internal WIDTH-bit reload register rl.
REQ-013 SHALL give load priority over en and auto_rl.
REQ-014 SHALL, on load=1, set rl<=sel and cnt<=sel, set tc<=0, and clear the prescale counter.
REQ-015 SHALL, on that load, enter RUN if sel!=0, or enter IDLE if sel==0.
REQ-016 SHALL, in IDLE without load, hold cnt, keep tc=0, and ignore en.
REQ-017 SHALL define a step as an enabled RUN cycle without load, or every PRESCALE-th such cycle when prescaling is compiled in.
REQ-018 SHALL, in RUN with en=0, hold cnt and the prescale count and force tc=0.
REQ-019 SHALL, on a step with cnt>1, set cnt<=cnt-1.
REQ-020 SHALL, on a step with cnt==1 and auto_rl=0, set cnt<=0, tc<=1 and move to IDLE.
REQ-021 SHALL, on a step with cnt==1 and auto_rl=1, set cnt<=rl, tc<=1 and stay in RUN.
REQ-022 SHALL sample auto_rl only on the terminal step.
REQ-023 SHALL produce a periodic-mode tc period of rl steps.
REQ-024 SHALL deassert tc on every cycle other than those set by REQ-020/REQ-021, so tc is never high on two consecutive cycles unless rl==1 in periodic mode.
REQ-025 SHALL, for periodic mode with rl==1, keep cnt at 1 and assert tc on every step.
REQ-026 SHALL, on load coinciding with a terminal step, take the load and force tc=0.
REQ-027 SHALL never let cnt underflow: no path decrements from 0 or wraps to 2^WIDTH-1.
REQ-028 SHALL drive busy as a direct decode of state==RUN, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on rst=1 at a rising baud edge, set cnt=0, rl=0, tc=0, busy=0, FSM=IDLE and prescale count=0.
REQ-030 SHALL give rst priority over load and en, including mid-count and on a terminal step.

Configuration
REQ-031 SHALL, with macro RDC_PRESCALE_EN defined, include a ceil(log2(PRESCALE))-bit prescaler so that one step occurs per PRESCALE enabled RUN cycles.
REQ-032 SHALL clear that prescaler on load, on rst, and on each step.
REQ-033 SHALL, with RDC_PRESCALE_EN undefined, omit the prescaler entirely, ignore PRESCALE, and make every enabled RUN cycle a step.

Verification
REQ-034 SHALL cover one-shot (no prescale): rst, load sel=5, en=1, auto_rl=0 -> cnt 5,4,3,2,1,0; tc=1 only on the cycle cnt=0; busy falls with it; cnt stays 0.
REQ-035 SHALL cover periodic (no prescale): load sel=3, en=1, auto_rl=1 -> cnt 3,2,1,3,2,1,...; tc every 3rd cycle; busy stays 1.
REQ-036 SHALL cover pause and collision: with cnt=4, en=0 for 3 cycles -> cnt holds at 4 with tc=0; with cnt=1, load sel=7 in the same cycle as en=1 -> cnt=7 and tc=0.
REQ-037 SHALL cover zero and reset: load sel=0 -> cnt=0, busy=0, no tc; with cnt=6 in RUN, assert rst together with load -> cnt=0 and busy=0 on the next cycle.
REQ-038 SHALL cover prescale (RDC_PRESCALE_EN, PRESCALE=4): load sel=2, en=1 -> cnt=1 after 4 cycles and cnt=0 with tc after 8 cycles; en=0 for 2 cycles mid-prescale extends the sequence by exactly 2 cycles.
